// File: rtl/core_pkg.sv
// Shared core types: LSU FSM states, memory access sizes and funct3 encodings.
// Pure declarations; no logic, no timing.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_size_e;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    // Bit 2 only selects signedness, so the size lives in the low two bits.
    function automatic mem_size_e sizeOf(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Store byte-lane/enable generation and load shift/extend.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module lsu_align
    import core_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NBYTES = XLEN / 8,
    parameter int OFFW   = $clog2(NBYTES)
) (
    input  logic [2:0]        storeFunct3,
    input  logic [OFFW-1:0]   storeOff,
    input  logic [XLEN-1:0]   storeData,
    output logic [NBYTES-1:0] storeBe,
    output logic [XLEN-1:0]   storeWdata,
    input  logic [2:0]        loadFunct3,
    input  logic [OFFW-1:0]   loadOff,
    input  logic [XLEN-1:0]   loadRdata,
    output logic [XLEN-1:0]   loadResult
);

    logic [XLEN-1:0] shifted;

    // Data is replicated across lanes so the enables alone pick the target bytes.
    always_comb begin
        storeBe    = '1;
        storeWdata = storeData;
        case (sizeOf(storeFunct3))
            SZ_B: begin
                storeBe    = NBYTES'(1) << storeOff;
                storeWdata = {NBYTES{storeData[7:0]}};
            end
            SZ_H: begin
                storeBe    = NBYTES'(3) << storeOff;
                storeWdata = {(NBYTES/2){storeData[15:0]}};
            end
            default: begin
                storeBe    = '1;
                storeWdata = storeData;
            end
        endcase
    end

    assign shifted = loadRdata >> {loadOff, 3'b000};

    always_comb begin
        loadResult = shifted;
        case (loadFunct3)
            FUNCT3_LB:  loadResult = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            FUNCT3_LH:  loadResult = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            FUNCT3_LBU: loadResult = {{(XLEN-8){1'b0}}, shifted[7:0]};
            FUNCT3_LHU: loadResult = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default:    loadResult = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit driving a valid/grant/rvalid data bus, one access in flight.
// Latency: store 2 cycles (accept, granted request), load 3 (accept, grant, rvalid).
// Backpressure: stall_o held until done_o; request fields frozen until dmem_gnt_i.
module load_store_unit
    import core_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NBYTES = XLEN / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   addr_i,
    input  logic [XLEN-1:0]   wdata_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [XLEN-1:0]   dmem_addr_o,
    output logic [NBYTES-1:0] dmem_be_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [XLEN-1:0]   dmem_rdata_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [XLEN-1:0]   load_data_o,
    output logic              misaligned_o,
    output logic              illegal_o
);

    localparam int OFFW = $clog2(NBYTES);

    lsu_state_e        state, stateNext;
    logic [2:0]        heldFunct3;
    logic [OFFW-1:0]   heldOff;
    logic [XLEN-1:0]   loadReg;
    logic [NBYTES-1:0] alignBe;
    logic [XLEN-1:0]   alignWdata;
    logic [XLEN-1:0]   loadExt;
    logic              access, illegalCond, misalignCond;
    logic              accept, capture;

    lsu_align #(.XLEN(XLEN), .NBYTES(NBYTES), .OFFW(OFFW)) uAlign (
        .storeFunct3 (funct3_i),
        .storeOff    (addr_i[OFFW-1:0]),
        .storeData   (wdata_i),
        .storeBe     (alignBe),
        .storeWdata  (alignWdata),
        .loadFunct3  (heldFunct3),
        .loadOff     (heldOff),
        .loadRdata   (dmem_rdata_i),
        .loadResult  (loadExt)
    );

    assign access = valid_i & (MemRead_i | MemWrite_i);

    always_comb begin
        illegalCond = MemRead_i & MemWrite_i;
        if (MemRead_i && (funct3_i == 3'b011 || funct3_i == 3'b110 || funct3_i == 3'b111))
            illegalCond = 1'b1;
        if (MemWrite_i && (funct3_i >= 3'b011))
            illegalCond = 1'b1;
        case (sizeOf(funct3_i))
            SZ_H:    misalignCond = addr_i[0];
            SZ_W:    misalignCond = (addr_i[1:0] != 2'b00);
            default: misalignCond = 1'b0;
        endcase
    end

    always_comb begin
        stateNext    = state;
        stall_o      = 1'b0;
        done_o       = 1'b0;
        misaligned_o = 1'b0;
        illegal_o    = 1'b0;
        accept       = 1'b0;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (illegalCond) begin
                        illegal_o = 1'b1;
                    end else if (misalignCond) begin
                        misaligned_o = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        stall_o   = 1'b1;
                        stateNext = REQ;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt_i && dmem_we_o) begin
                    done_o    = 1'b1;
                    stateNext = IDLE;
                end else begin
                    stall_o = 1'b1;
                    if (dmem_gnt_i)
                        stateNext = WAIT_R;
                end
            end
            WAIT_R: begin
                if (dmem_rvalid_i) begin
                    capture   = 1'b1;
                    done_o    = 1'b1;
                    stateNext = IDLE;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= '0;
            dmem_wdata_o <= '0;
            heldFunct3   <= '0;
            heldOff      <= '0;
            loadReg      <= '0;
        end else begin
            state <= stateNext;
            if (accept) begin
                dmem_req_o   <= 1'b1;
                dmem_we_o    <= MemWrite_i;
                dmem_addr_o  <= {addr_i[XLEN-1:OFFW], {OFFW{1'b0}}};
                dmem_be_o    <= alignBe;
                dmem_wdata_o <= alignWdata;
                heldFunct3   <= funct3_i;
                heldOff      <= addr_i[OFFW-1:0];
            end else if (state == REQ && dmem_gnt_i) begin
                dmem_req_o <= 1'b0;
            end
            if (capture)
                loadReg <= loadExt;
        end
    end

    // The completing load's data is visible in its done_o cycle, then held.
    assign load_data_o = capture ? loadExt : loadReg;

    busStable: assert property (@(posedge clk_i) disable iff (rst_i)
        (dmem_req_o && !dmem_gnt_i) |=> (dmem_req_o && $stable(dmem_we_o) &&
        $stable(dmem_addr_o) && $stable(dmem_be_o) && $stable(dmem_wdata_o)));

    doneExclusive: assert property (@(posedge clk_i) disable iff (rst_i)
        !(done_o && (misaligned_o || illegal_o)));

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i, MemRead_i, MemWrite_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        stall_o, done_o;
    logic [31:0] load_data_o;
    logic        misaligned_o, illegal_o;

    int total = 0;
    int bad   = 0;

    load_store_unit #(.XLEN(32), .NBYTES(4)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .valid_i       (valid_i),
        .MemRead_i     (MemRead_i),
        .MemWrite_i    (MemWrite_i),
        .funct3_i      (funct3_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .stall_o       (stall_o),
        .done_o        (done_o),
        .load_data_o   (load_data_o),
        .misaligned_o  (misaligned_o),
        .illegal_o     (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the edge; checks land 1ns later, well clear of the next edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        valid_i    = 1'b1;
        MemRead_i  = rd;
        MemWrite_i = wr;
        funct3_i   = f3;
        addr_i     = addr;
        wdata_i    = wd;
    endtask

    task automatic dropValid();
        valid_i    = 1'b0;
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
    endtask

    task automatic doLoad(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp);
        drive(1'b1, 1'b0, f3, addr, 32'h0);
        #1 chk({tag, "_acc_stall"}, 32'(stall_o), 32'd1);
        step();
        dropValid();
        dmem_gnt_i = 1'b1;
        #1;
        chk({tag, "_req"},  32'(dmem_req_o), 32'd1);
        chk({tag, "_we"},   32'(dmem_we_o), 32'd0);
        chk({tag, "_addr"}, dmem_addr_o, {addr[31:2], 2'b00});
        chk({tag, "_gnt_done"}, 32'(done_o), 32'd0);
        step();
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = rdata;
        #1;
        chk({tag, "_wr_req"}, 32'(dmem_req_o), 32'd0);
        chk({tag, "_done"},  32'(done_o), 32'd1);
        chk({tag, "_stall"}, 32'(stall_o), 32'd0);
        chk({tag, "_data"},  load_data_o, exp);
        step();
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'h0;
        #1;
        chk({tag, "_done_after"}, 32'(done_o), 32'd0);
        chk({tag, "_hold"}, load_data_o, exp);
    endtask

    task automatic doStore(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] expBe,
                           input logic [31:0] expWd, input logic [31:0] expLoad);
        drive(1'b0, 1'b1, f3, addr, wd);
        step();
        dropValid();
        #1;
        chk({tag, "_req"},  32'(dmem_req_o), 32'd1);
        chk({tag, "_we"},   32'(dmem_we_o), 32'd1);
        chk({tag, "_addr"}, dmem_addr_o, {addr[31:2], 2'b00});
        chk({tag, "_be"},   32'(dmem_be_o), 32'(expBe));
        chk({tag, "_wdata"}, dmem_wdata_o, expWd);
        dmem_gnt_i = 1'b1;
        #1 chk({tag, "_done"}, 32'(done_o), 32'd1);
        step();
        dmem_gnt_i = 1'b0;
        #1;
        chk({tag, "_req_drop"}, 32'(dmem_req_o), 32'd0);
        chk({tag, "_loadkeep"}, load_data_o, expLoad);
    endtask

    task automatic doErr(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic expMis, input logic expIll);
        drive(rd, wr, f3, addr, 32'h1234_5678);
        #1;
        chk({tag, "_mis"},   32'(misaligned_o), 32'(expMis));
        chk({tag, "_ill"},   32'(illegal_o), 32'(expIll));
        chk({tag, "_stall"}, 32'(stall_o), 32'd0);
        step();
        dropValid();
        #1;
        chk({tag, "_mis_pulse"}, 32'(misaligned_o), 32'd0);
        chk({tag, "_ill_pulse"}, 32'(illegal_o), 32'd0);
        chk({tag, "_noreq"}, 32'(dmem_req_o), 32'd0);
        step();
        chk({tag, "_noreq2"}, 32'(dmem_req_o), 32'd0);
    endtask

    initial begin
        rst_i = 1'b1;
        valid_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
        funct3_i = 3'b0; addr_i = 32'h0; wdata_i = 32'h0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
        step();
        step();
        chk("rst_req",   32'(dmem_req_o), 32'd0);
        chk("rst_we",    32'(dmem_we_o), 32'd0);
        chk("rst_addr",  dmem_addr_o, 32'h0);
        chk("rst_be",    32'(dmem_be_o), 32'h0);
        chk("rst_wdata", dmem_wdata_o, 32'h0);
        chk("rst_load",  load_data_o, 32'h0);
        chk("rst_done",  32'(done_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        rst_i = 1'b0;
        step();

        // SW with two ungranted cycles
        drive(1'b0, 1'b1, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF);
        #1;
        chk("sw_acc_stall", 32'(stall_o), 32'd1);
        chk("sw_acc_noreq", 32'(dmem_req_o), 32'd0);
        step();
        dropValid();
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("sw_wait_req",   32'(dmem_req_o), 32'd1);
            chk("sw_wait_addr",  dmem_addr_o, 32'h0000_1000);
            chk("sw_wait_be",    32'(dmem_be_o), 32'hF);
            chk("sw_wait_wdata", dmem_wdata_o, 32'hDEAD_BEEF);
            chk("sw_wait_stall", 32'(stall_o), 32'd1);
            chk("sw_wait_done",  32'(done_o), 32'd0);
            step();
        end
        dmem_gnt_i = 1'b1;
        #1;
        chk("sw_gnt_done",  32'(done_o), 32'd1);
        chk("sw_gnt_stall", 32'(stall_o), 32'd0);
        step();
        dmem_gnt_i = 1'b0;
        #1;
        chk("sw_after_req",   32'(dmem_req_o), 32'd0);
        chk("sw_after_done",  32'(done_o), 32'd0);
        chk("sw_after_stall", 32'(stall_o), 32'd0);

        doStore("sb", 3'b000, 32'h0000_1003, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5, 32'h0);
        doLoad("lb",  3'b000, 32'h0000_2001, 32'h0000_8000, 32'hFFFF_FF80);
        doLoad("lbu", 3'b100, 32'h0000_2001, 32'h0000_8000, 32'h0000_0080);
        doLoad("lh",  3'b001, 32'h0000_2002, 32'h8001_0000, 32'hFFFF_8001);
        doLoad("lhu", 3'b101, 32'h0000_2002, 32'h8001_0000, 32'h0000_8001);
        doLoad("lw",  3'b010, 32'h0000_3000, 32'h1234_5678, 32'h1234_5678);
        doStore("sh", 3'b001, 32'h0000_1002, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF, 32'h1234_5678);

        doErr("lw_mis",   1'b1, 1'b0, 3'b010, 32'h0000_3002, 1'b1, 1'b0);
        doErr("sh_mis",   1'b0, 1'b1, 3'b001, 32'h0000_3001, 1'b1, 1'b0);
        doErr("ld_f3bad", 1'b1, 1'b0, 3'b011, 32'h0000_3000, 1'b0, 1'b1);
        doErr("st_f3bad", 1'b0, 1'b1, 3'b100, 32'h0000_3000, 1'b0, 1'b1);
        doErr("rdwr",     1'b1, 1'b1, 3'b010, 32'h0000_3000, 1'b0, 1'b1);
        doErr("ill_prio", 1'b1, 1'b1, 3'b010, 32'h0000_3003, 1'b0, 1'b1);

        // Reset while waiting for read data; a late rvalid must be ignored
        drive(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0);
        step();
        dropValid();
        dmem_gnt_i = 1'b1;
        step();
        dmem_gnt_i = 1'b0;
        #1;
        chk("rstw_wait_stall", 32'(stall_o), 32'd1);
        chk("rstw_wait_req",   32'(dmem_req_o), 32'd0);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hFFFF_FFFF;
        #1;
        chk("rstw_req",   32'(dmem_req_o), 32'd0);
        chk("rstw_done",  32'(done_o), 32'd0);
        chk("rstw_stall", 32'(stall_o), 32'd0);
        chk("rstw_load",  load_data_o, 32'h0);
        step();
        dmem_rvalid_i = 1'b0;
        #1;
        chk("rstw_load2", load_data_o, 32'h0);
        chk("rstw_done2", 32'(done_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
